adder_seq32: RTL and testbench
==============================

# adder_seq32

Byte-serial 32-bit add/subtract unit that sequences a single `adder8` over four clock cycles instead of instantiating four of them. It sits beside the ALU for area-constrained builds and serves multi-cycle address and immediate arithmetic. It accepts one operation at a time over a valid/ready request port and returns the result over a valid/ready response port.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes; data width is 8*`NUM_BYTES`. Only 4 is supported and verified.
- `clk_i`  in  1  the single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  1  a request is present on `a_i`, `b_i`, `sub_i`.
- `req_ready_o`  out  1  the block can accept a request; high only in IDLE.
- `a_i`  in  32  operand A.
- `b_i`  in  32  operand B.
- `sub_i`  in  1  0 = A+B, 1 = A−B.
- `res_valid_o`  out  1  result outputs are valid; high only in DONE.
- `res_ready_i`  in  1  the consumer accepts the result.
- `sum_o`  out  32  result, modulo 2^32.
- `carry_o`  out  1  carry out of bit 31; for subtraction 1 means no borrow.
- `overflow_o`  out  1  signed overflow.
- `zero_o`  out  1  `sum_o` == 0.

## Operation
- The FSM has three states: IDLE, CALC, DONE. A 2-bit byte counter `cnt` and a 1-bit carry register drive the sequence.
- **IDLE.** `req_ready_o`=1. On `req_valid_i && req_ready_o`:
  - Latch `a_i` into `a_q`.
  - Latch `sub_i ? ~b_i : b_i` into `b_q`.
  - Load carry_q = `sub_i`, `cnt`=0.
  - Go to CALC.
- **CALC.** Each cycle, `adder8` adds byte `cnt` of `a_q`, byte `cnt` of `b_q`, and carry_q.
  - Its sum is written into byte `cnt` of the result register.
  - Its carry_out is written into carry_q.
  - `cnt` increments.
  - After byte 3 is written, go to DONE. `carry_o` takes the final carry.
- **DONE.** `res_valid_o`=1. `sum_o`, `carry_o`, `overflow_o` and `zero_o` stay stable until `res_valid_o && res_ready_i`; then go to IDLE.
- `overflow_o` = (`a_q`[31] == `b_q`[31]) && (`sum_o`[31] != `a_q`[31]), where `b_q` is the already-inverted operand.
- `zero_o` = ~|`sum_o`.
- Requests are ignored outside IDLE: `req_ready_o`=0, and the latched operands are unaffected.
- Result registers keep their last value after the response handshake, until the next operation overwrites them byte by byte.

## Timing
- Reset (`rst_i` high at an edge) forces:
  - state IDLE, `cnt`=0, carry_q=0;
  - `sum_o`=0, `carry_o`=0, `overflow_o`=0, `zero_o`=0, `res_valid_o`=0;
  - `req_ready_o`=1 from the first cycle after reset.
- Reset has priority over every handshake in the same cycle.
- Reset mid-CALC or mid-DONE discards the operation. No `res_valid_o` pulse is produced for it.
- Latency: request accepted at edge E0, then bytes 0..3 are written at E1..E4. `res_valid_o` is high from E4 onward, 4 cycles after acceptance.
- Throughput: if `res_ready_i` is high in the first DONE cycle, the handshake completes at E5. IDLE follows, the next accept is at E6 at the earliest, giving 1 operation per 6 cycles.
- Backpressure: DONE holds for any number of cycles while `res_ready_i`=0, with outputs unchanged.
- `req_ready_o` and `res_valid_o` are decoded directly from registered state and never depend combinationally on `req_valid_i` or `res_ready_i`.

## Structure
- Package `adder_seq_pkg`:
  - state enum `seq_state_t` {IDLE, CALC, DONE};
  - localparams `BYTE_W`=8, `NUM_BYTES`=4, `CNT_W`=2.
- One sub-module: a single instance of the existing `adder8` (ports: 8-bit `a`, 8-bit `b`, `carry_in`, 8-bit `sum`, `carry_out`). Its byte inputs are selected by `cnt`.
- No other arithmetic operators in the RTL apart from the `cnt` increment.

## Test plan
- Add a=0x0000_00FF, b=0x0000_0001 → sum 0x0000_0100, carry 0, overflow 0, zero 0. `res_valid_o` rises exactly 4 cycles after the accept edge.
- Add a=0xFFFF_FFFF, b=0x0000_0001 → sum 0x0000_0000, carry 1, zero 1, overflow 0. Separately, add a=0x7FFF_FFFF, b=1 → 0x8000_0000, overflow 1.
- Subtract a=5, b=7 → 0xFFFF_FFFE, carry 0, overflow 0. Subtract a=0x8000_0000, b=1 → 0x7FFF_FFFF, carry 1, overflow 1.
- Backpressure: hold `res_ready_i`=0 for 3 cycles in DONE while driving `req_valid_i`=1 with new operands.
  - Outputs stay stable and `req_ready_o` stays 0.
  - The new request is accepted only after the response handshake and the return to IDLE.
- Reset mid-op: assert `rst_i` for one cycle when `cnt`=2 → next cycle state IDLE, `req_ready_o`=1, all result outputs 0, and no `res_valid_o` is ever raised for that operation.
- Back-to-back: tie `res_ready_i`=1 and `req_valid_i`=1, then run 100 random add/sub operations → results match a reference model and accepts are exactly 6 cycles apart.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and sizes for the byte-serial 32-bit add/subtract unit.
package adder_seq_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = 4;
   localparam int unsigned CNT_W     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/adder8.sv
// 8-bit ripple-carry adder slice, reused once per byte by adder_seq32.
module adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] sum,
   output logic       carry_out
);

   logic carry;

   // Ripple the carry through each bit position.
   always_comb begin
      carry = carry_in;
      sum   = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      carry_out = carry;
   end

endmodule

// File: rtl/adder_seq32.sv
// Byte-serial 32-bit add/subtract: one adder8 stepped over four cycles,
// with valid/ready request and response ports.
module adder_seq32 #(
   parameter int unsigned NUM_BYTES = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [8*NUM_BYTES-1:0]   a_i,
   input  logic [8*NUM_BYTES-1:0]   b_i,
   input  logic                     sub_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [8*NUM_BYTES-1:0]   sum_o,
   output logic                     carry_o,
   output logic                     overflow_o,
   output logic                     zero_o
);

   import adder_seq_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

   typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] word_t;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;
   word_t             a_q, a_d;
   word_t             b_q, b_d;
   word_t             res_q, res_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic [BYTE_W-1:0] add_sum;
   logic              add_cout;

   // The single shared byte adder; operand bytes picked by the counter.
   adder8 u_adder8 (
      .a         (a_q[cnt_q]),
      .b         (b_q[cnt_q]),
      .carry_in  (carry_q),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   // Next-state, operand latch and per-byte result accumulation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
               a_d     = a_i;
               b_d     = sub_i ? ~b_i : b_i;
               carry_d = sub_i;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d[cnt_q] = add_sum;
            carry_d      = add_cout;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               cout_d  = add_cout;
               ovf_d   = (a_q[NUM_BYTES-1][BYTE_W-1] == b_q[NUM_BYTES-1][BYTE_W-1]) &&
                         (add_sum[BYTE_W-1] != a_q[NUM_BYTES-1][BYTE_W-1]);
               zero_d  = ~|res_d;
            end
         end
         DONE: begin
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign res_valid_o = (state_q == DONE);
   assign sum_o       = res_q;
   assign carry_o     = cout_q;
   assign overflow_o  = ovf_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_adder_seq32.sv
// Self-checking bench for adder_seq32: directed corner cases, backpressure,
// mid-operation reset and a back-to-back random run against a reference model.
module tb_adder_seq32;

   logic        clk;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        sub_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [31:0] sum_o;
   logic        carry_o;
   logic        overflow_o;
   logic        zero_o;

   int errors = 0;
   int checks = 0;

   adder_seq32 #(.NUM_BYTES(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .sub_i       (sub_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .sum_o       (sum_o),
      .carry_o     (carry_o),
      .overflow_o  (overflow_o),
      .zero_o      (zero_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 32-bit arithmetic plus signed range test for overflow.
   // Packed as {sum[31:0], carry, overflow, zero}.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          sr;
      logic [31:0]     s;
      logic            c;
      logic            o;
      logic            z;
      if (sub) begin
         s  = a - b;
         c  = (a >= b);
         sr = sa - sb;
      end else begin
         s  = a + b;
         c  = (ua + ub) > 64'hFFFF_FFFF;
         sr = sa + sb;
      end
      o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (s == 32'd0);
      return {s, c, o, z};
   endfunction

   function automatic logic [34:0] observed();
      return {sum_o, carry_o, overflow_o, zero_o};
   endfunction

   // Present a request from IDLE, check 4-cycle latency and result; optionally
   // complete the response handshake.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [34:0] exp, input logic release_res);
      int lat;
      a_i = a; b_i = b; sub_i = sub; req_valid_i = 1'b1;
      chk({tag, "/ready"}, 64'(req_ready_o), 64'd1);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      lat = 0;
      while (!res_valid_o && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "/latency"}, 64'(lat), 64'd4);
      chk({tag, "/result"}, 64'(observed()), 64'(exp));
      if (release_res) begin
         res_ready_i = 1'b1;
         @(posedge clk); #1;
         res_ready_i = 1'b0;
         chk({tag, "/idle"}, 64'({res_valid_o, req_ready_o}), 64'b01);
         chk({tag, "/kept"}, 64'(observed()), 64'(exp));
      end
   endtask

   initial begin
      logic [34:0] exp_q[$];
      logic [34:0] held;
      logic [34:0] exp_next;
      logic        seen;
      logic        acc;
      int          accepts;
      int          results;
      int          last_acc;
      int          cyc;

      rst_i = 1'b1; req_valid_i = 1'b0; res_ready_i = 1'b0;
      a_i = '0; b_i = '0; sub_i = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("reset/outputs", 64'({req_ready_o, res_valid_o, sum_o, carry_o, overflow_o, zero_o}),
          64'({1'b1, 1'b0, 32'd0, 3'b000}));
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("reset/ready", 64'(req_ready_o), 64'd1);

      // Directed corner cases
      run_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, {32'h0000_0100, 3'b000}, 1'b1);
      run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 3'b101}, 1'b1);
      run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 3'b010}, 1'b1);
      run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, {32'hFFFF_FFFE, 3'b000}, 1'b1);
      run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 3'b110}, 1'b1);

      // Backpressure: DONE held while a new request waits
      held = model(32'h1234_5678, 32'h0101_0101, 1'b0);
      run_op("bp_first", 32'h1234_5678, 32'h0101_0101, 1'b0, held, 1'b0);
      a_i = 32'hDEAD_BEEF; b_i = 32'h0000_BEEF; sub_i = 1'b1; req_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("bp/hold_result", 64'(observed()), 64'(held));
         chk("bp/hold_flags", 64'({res_valid_o, req_ready_o}), 64'b10);
      end
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      res_ready_i = 1'b0;
      chk("bp/back_idle", 64'({res_valid_o, req_ready_o}), 64'b01);
      run_op("bp_second", 32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1,
             model(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1), 1'b1);

      // Reset while cnt is 2
      a_i = 32'hAAAA_5555; b_i = 32'h1111_2222; sub_i = 1'b0; req_valid_i = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("midrst/outputs", 64'({req_ready_o, res_valid_o, sum_o, carry_o, overflow_o, zero_o}),
          64'({1'b1, 1'b0, 32'd0, 3'b000}));
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (res_valid_o) seen = 1'b1;
      end
      chk("midrst/no_valid", 64'(seen), 64'd0);

      // Back-to-back random operations with both handshakes tied high
      accepts = 0; results = 0; last_acc = -1; cyc = 0;
      a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom_range(0, 1));
      res_ready_i = 1'b1; req_valid_i = 1'b1;
      while ((accepts < 100 || results < 100) && cyc < 2000) begin
         acc = req_valid_i && req_ready_o;
         if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("b2b/orphan_result", 64'd1, 64'd0);
            end else begin
               exp_next = exp_q.pop_front();
               chk("b2b/result", 64'(observed()), 64'(exp_next));
            end
            results++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            exp_q.push_back(model(a_i, b_i, sub_i));
            if (last_acc >= 0) chk("b2b/accept_gap", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
            accepts++;
            if (accepts == 100) begin
               req_valid_i = 1'b0;
            end else begin
               a_i   = $urandom;
               b_i   = ($urandom_range(0, 7) == 0) ? a_i : $urandom;
               sub_i = 1'($urandom_range(0, 1));
            end
         end
      end
      chk("b2b/accepts", 64'(accepts), 64'd100);
      chk("b2b/results", 64'(results), 64'd100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
